div_ratio_checker: RTL

//  Receive-side monitor for divided clocks made by the even clock divider (clk_div2/4/10).

---
 rtl/div_ratio_checker.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/div_ratio_checker.sv
// Divided-clock monitor: measures period/high time of div_in in clk cycles, checks ratio, flags lock/mismatch/stall.
// Optional duty-cycle check is enabled by defining DUTY_CHECK_EN (adds the duty_err output).
module div_ratio_checker #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             period_vld,
  output logic             lock,
  output logic             mism_err,
  output logic             timeout
`ifdef DUTY_CHECK_EN
  ,
  output logic             duty_err
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

  state_t           state;
  state_t           state_nxt;
  logic             d1;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic [3:0]       match_cnt;
  logic [3:0]       match_inc;
  logic             rise;
  logic             fall;
  logic             sat;
  logic             meas;
  logic             match;
  logic             duty_blk;

  // div_in comes from clk-domain flops, so one register is enough for edge detection.
  assign rise = div_in & ~d1;
  assign fall = ~div_in & d1;

  // A period that reaches the counter ceiling is a stall; it outranks a coincident rise.
  assign sat  = (state != IDLE) && (cnt == CNT_MAX);
  assign meas = rise && (state != IDLE) && !sat;

  // Periods of 0 or 1 cannot come from a clk-domain source, so such expectations never match.
  assign match     = (cnt == exp_period) && (exp_period >= CNT_W'(2));
  assign match_inc = (match_cnt >= LOCK_TGT) ? LOCK_TGT : match_cnt + 4'd1;

`ifdef DUTY_CHECK_EN
  logic [CNT_W+1:0] duty_diff;
  logic [CNT_W+1:0] duty_abs;
  logic             duty_bad;

  assign duty_diff = {1'b0, hcnt, 1'b0} - {2'b00, cnt};
  assign duty_abs  = duty_diff[CNT_W+1] ? (~duty_diff + (CNT_W+2)'(1)) : duty_diff;
  assign duty_bad  = duty_abs > (CNT_W+2)'(1);
  // A violation seen on this very period also blocks entry to LOCKED.
  assign duty_blk  = duty_err | (meas & duty_bad);
`else
  assign duty_blk  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state always uses <= so every flop samples pre-edge values.
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rise) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (sat) begin
          state_nxt = IDLE;
        end else if (meas && match && (match_inc == LOCK_TGT) && !duty_blk) begin
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (sat) begin
          state_nxt = IDLE;
        end else if (meas && !match) begin
          state_nxt = MEASURE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    lock = (state == LOCKED);
`ifdef DUTY_CHECK_EN
    if (duty_err) lock = 1'b0;
`endif
  end

  // Measurement datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register here is a small flop, so all of them reset; no partial measurement survives.
      d1        <= 1'b0;
      cnt       <= '0;
      hcnt      <= '0;
      match_cnt <= '0;
    end else begin
      d1 <= div_in;

      if (sat) begin
        cnt <= '0;
      end else if (rise) begin
        cnt <= CNT_W'(1);
      end else if (state == IDLE) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (rise) begin
        hcnt <= CNT_W'(1);
      end else if (d1 && !fall && (hcnt != CNT_MAX)) begin
        hcnt <= hcnt + CNT_W'(1);
      end

      if (sat || (state == IDLE)) begin
        match_cnt <= '0;
      end else if (meas) begin
        match_cnt <= match ? match_inc : 4'd0;
      end
    end
  end

  // Reported results and sticky flags; a new error outranks a coincident err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_o   <= '0;
      high_o     <= '0;
      period_vld <= 1'b0;
      mism_err   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      period_vld <= meas;
      if (meas) begin
        period_o <= cnt;
        high_o   <= hcnt;
      end
      mism_err <= (meas && (state == LOCKED) && !match) | (mism_err & ~err_clr);
      timeout  <= sat | (timeout & ~err_clr);
    end
  end

`ifdef DUTY_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_err <= 1'b0;
    end else begin
      duty_err <= (meas & duty_bad) | (duty_err & ~err_clr);
    end
  end
`endif

endmodule
